// File: rtl/gray_decode_arbiter.sv
// Round-robin shares one Gray-to-binary converter among N_REQ requesters; result registered with winner ID.
// Latency 1 cycle from grant; single-entry output, gnt held low while the result is stalled by out_ready.
module gray_decode_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 3,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   gr_in,
  output logic [N_REQ-1:0]     gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_bin,
  output logic [W-1:0]         out_gray,
  output logic [IDW-1:0]       out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic             slot_free;
  logic             grant;
  logic [W-1:0]     gr_sel;
  logic [W-1:0]     bin_sel;
  int               idx;

  assign slot_free = (state_q == EMPTY) || out_ready;
  // rst_n gate keeps gnt low during an asynchronous reset, when the slot reads as free
  assign grant     = rst_n && slot_free && win_found;

  // first set request searching upward from rr_ptr, wrapping at N_REQ
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (grant) gnt[win_id] = 1'b1;
  end

  assign gr_sel = gr_in[int'(win_id)*W +: W];

  always_comb begin
    bin_sel        = '0;
    bin_sel[W-1]   = gr_sel[W-1];
    for (int k = W-2; k >= 0; k--) begin
      bin_sel[k] = bin_sel[k+1] ^ gr_sel[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      out_bin  <= '0;
      out_gray <= '0;
      out_id   <= '0;
    end else if (grant) begin
      rr_ptr   <= (win_id == IDW'(N_REQ-1)) ? '0 : win_id + 1'b1;
      out_bin  <= bin_sel;
      out_gray <= gr_sel;
      out_id   <= win_id;
    end
  end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter: grant order, conversion, backpressure, drain and async reset.
module tb_gray_decode_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 3;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] gr_in;
  logic [N_REQ-1:0]   gnt;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_bin;
  logic [W-1:0]       out_gray;
  logic [IDW-1:0]     out_id;

  int n_checks;
  int n_pass;

  gray_decode_arbiter #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gr_in     (gr_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance to just after the next rising edge, where inputs are driven
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] b,
                         input logic [W-1:0] g, input logic [IDW-1:0] id);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".bin"},   32'(out_bin),   32'(b));
    check({tag, ".gray"},  32'(out_gray),  32'(g));
    check({tag, ".id"},    32'(out_id),    32'(id));
  endtask

  logic [3:0] rr_gnt [5];
  logic [2:0] rr_bin [5];
  logic [2:0] rr_gry [5];

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b0;
    gr_in     = '0;
    #2;
    check("rst.gnt", 32'(gnt), 32'h0);
    chk_out("rst", 1'b0, 3'b000, 3'b000, 2'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request, then drain
    cyc();
    req = 4'b0001; gr_in = {3'b000, 3'b000, 3'b000, 3'b010}; out_ready = 1'b1;
    @(negedge clk);
    check("single.gnt", 32'(gnt), 32'b0001);
    cyc();
    req = '0;
    @(negedge clk);
    chk_out("single", 1'b1, 3'b011, 3'b010, 2'd0);
    check("drain.gnt", 32'(gnt), 32'h0);
    cyc();
    @(negedge clk);
    check("drain.valid", 32'(out_valid), 32'h0);

    // fresh reset so round-robin starts from requester 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_bin = '{3'b010, 3'b100, 3'b101, 3'b111, 3'b010};
    rr_gry = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b011};
    cyc();
    req = 4'b1111; gr_in = {3'b100, 3'b111, 3'b110, 3'b011}; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(rr_gnt[i]));
      if (i > 0)
        chk_out($sformatf("rr%0d", i), 1'b1, rr_bin[i-1], rr_gry[i-1], IDW'((i-1) % N_REQ));
      cyc();
    end
    // result of 5th grant (requester 0) now registered, rr_ptr = 1
    req = 4'b0110; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d.gnt", i), 32'(gnt), 32'h0);
      chk_out($sformatf("bp%0d", i), 1'b1, 3'b010, 3'b011, 2'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.gnt", 32'(gnt), 32'b0010);
    cyc();
    req = 4'b1000;
    @(negedge clk);
    chk_out("bp.load", 1'b1, 3'b100, 3'b110, 2'd1);
    check("wrap.g3", 32'(gnt), 32'b1000);
    cyc();
    req = 4'b0101;
    @(negedge clk);
    check("wrap.g0", 32'(gnt), 32'b0001);
    chk_out("wrap.r3", 1'b1, 3'b111, 3'b100, 2'd3);
    cyc();
    @(negedge clk);
    check("skip.g2", 32'(gnt), 32'b0100);
    chk_out("wrap.r0", 1'b1, 3'b010, 3'b011, 2'd0);
    cyc();
    req = '0; out_ready = 1'b0;
    @(negedge clk);
    chk_out("skip.r2", 1'b1, 3'b101, 3'b111, 2'd2);

    // asynchronous reset while FULL and stalled
    #2;
    rst_n = 1'b0;
    req   = 4'b1010;
    #1;
    chk_out("arst", 1'b0, 3'b000, 3'b000, 2'd0);
    check("arst.gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post.gnt", 32'(gnt), 32'b0010);
    cyc();
    @(negedge clk);
    chk_out("post", 1'b1, 3'b100, 3'b110, 2'd1);
    check("post.gnt2", 32'(gnt), 32'b1000);
    cyc();
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_decode_arbiter.md
Name: gray_decode_arbiter

Overview:
- Shares one W-bit Gray-to-binary converter among N_REQ requesters.
- Each requester presents a Gray code with a request. A round-robin arbiter grants one requester per cycle, and the converted binary value is registered with the winner's ID.
- The output side uses a single-entry valid/ready interface.
- Sits between Gray-coded sources (encoder positions, pointer samples) and binary-consuming logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 3, Gray/binary word width (>=2).
- IDW, 2, requester ID width; must satisfy 2**IDW >= N_REQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request; bit i belongs to requester i.
- gr_in  input  N_REQ*W  Gray words; requester i uses bits [i*W+W-1 : i*W].
- gnt  output  N_REQ  one-hot combinational grant; the data is captured on this edge.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_bin  output  W  converted binary value.
- out_gray  output  W  original Gray word, echoed.
- out_id  output  IDW  index of the requester that was granted.

Behaviour:
- Conversion:
  - bin[W-1] = gr[W-1].
  - bin[k] = bin[k+1] ^ gr[k], for k = W-2 down to 0.
  - Applied combinationally to the selected gr_in slice; the result is registered.
- Slot free: slot_free = !out_valid || out_ready.
- Arbitration:
  - Active only when slot_free and |req.
  - The winner is the first set req bit searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
  - gnt[winner] = 1; all other gnt bits are 0.
  - gnt is all-zero when slot_free = 0 or req = 0.
- On a grant edge:
  - out_bin, out_gray and out_id load the winner's values; out_valid becomes 1.
  - rr_ptr becomes (winner+1) mod N_REQ.
- rr_ptr is unchanged on cycles with no grant.
- Latency: a grant in cycle t gives out_valid = 1 in cycle t+1.
- Throughput: one result per cycle while out_ready is held 1 and requests are pending.
- Output state machine:
  - EMPTY (out_valid = 0): a grant moves to FULL; otherwise stay in EMPTY.
  - FULL (out_valid = 1):
    - out_ready = 1 with a grant: stay FULL and load the new result (simultaneous pop and push).
    - out_ready = 1 with no grant: go to EMPTY.
    - out_ready = 0: stay FULL, hold out_bin/out_gray/out_id bit-stable, gnt = 0.
- Requester protocol:
  - The requester holds req and its gr_in slice stable until the cycle in which gnt[i] = 1.
  - A requester that keeps req high after its grant is treated as a new request.
  - Any requester is granted within N_REQ grants (starvation-free).
- Reset (asynchronous, any time, including while FULL):
  - out_valid = 0; out_bin, out_gray and out_id = 0; rr_ptr = 0.
  - gnt = 0 while rst_n = 0.
  - A pending result is discarded.
  - After release, requester 0 has first priority.
- Inputs are not checked for single-bit Gray steps; every W-bit code is converted.

Test Plan:
- Single request: req = 0001, requester 0 slice = 010, out_ready = 1 -> gnt = 0001 in the same cycle; next cycle out_valid = 1, out_bin = 011, out_gray = 010, out_id = 0.
- Round-robin: req = 1111 held, slices = 011 / 110 / 111 / 100, out_ready = 1 -> grants in order 0, 1, 2, 3, 0; out_bin sequence 010, 100, 101, 111, 010; one result per cycle.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with req = 0110 -> gnt = 0000 and outputs stable; the cycle out_ready rises -> gnt = 0010 (rr_ptr = 1) and the new result loads in the same edge.
- Pointer wrap and skip: after a grant to requester 3, req = 0101 -> requester 0 granted, then requester 2.
- Drain: one result pending, req = 0, out_ready = 1 -> out_valid drops to 0 the next cycle.
- Reset mid-operation: assert rst_n = 0 while FULL with out_ready = 0 -> out_valid = 0 and outputs = 0 immediately, before the next clk edge; after release, req = 1010 -> requester 1 granted first.
